// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
//
// Contents:
//   loader_state_t  - loader FSM states
//   LEN_BYTES       - bytes in the length prefix of the stream
//   BYTES_PER_WORD  - bytes packed into one instruction word
//   WORD_W          - instruction word width in bits
//   BYTE_CNT_W      - width of the byte-within-word counter
//   is_stream_state - true in the states that consume stream bytes
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * 8;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // The stream side is only ready while the loader is collecting the length
  // prefix or instruction bytes; every other state leaves bytes untouched.
  function automatic logic is_stream_state(loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake between a program source and the loader.
//
// Signals:
//   byte_in    - stream data byte (source -> loader)
//   byte_valid - byte_in holds a valid byte (source -> loader)
//   byte_ready - loader takes the byte this cycle (loader -> source)
// A byte transfers on a rising clock edge where byte_valid && byte_ready.
//
// Modports:
//   master - the byte source
//   slave  - the loader
interface program_loader_if;

  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs accepted stream bytes little-endian into instruction words.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-high reset
//   clear_i     - restart packing at byte 0 of a fresh word
//   accept_i    - byte_i is being accepted this cycle
//   byte_i      - incoming stream byte
//   word_o      - assembled word including the byte being accepted now
//   word_full_o - the byte accepted this cycle completes a word
module byte_packer
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_o
);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  logic [BYTE_CNT_W-1:0] byte_cnt_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_d;
  logic [WORD_W-1:0]     shift_q;
  logic [WORD_W-1:0]     shift_d;

  // Each new byte enters at the top and older bytes move down, so after a
  // full word the first byte of the word sits in bits [7:0]. The word is
  // exposed with the current byte already merged in, which lets the parent
  // capture a complete word on the same edge its last byte arrives.
  assign word_o      = {byte_i, shift_q[WORD_W-1:8]};
  assign word_full_o = accept_i && (byte_cnt_q == LAST_BYTE);

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      shift_d    = '0;
    end else if (accept_i) begin
      // The counter wraps naturally back to 0 after the last byte of a word.
      byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
      shift_d    = word_o;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader. Receives a length-prefixed byte stream, packs it
// into 32-bit instructions, writes them into instruction memory and holds the
// core in reset until the whole program is resident.
//
// Stream format: 2-byte little-endian word count N, then 4*N bytes, each
// word little-endian.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - one-cycle pulse starting a load (taken in IDLE/DONE/ERR)
//   strm       - byte stream handshake (slave side)
//   imem_we    - instruction memory write strobe, one cycle per word
//   imem_addr  - word-aligned byte address of the word being written
//   imem_wdata - instruction word being written
//   cpu_reset  - core reset, low only once a complete program is loaded
//   done       - program loaded and core released
//   error      - length prefix rejected
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 64
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  program_loader_if.slave   strm,
  output logic              imem_we,
  output logic [63:0]       imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [15:0] MAX_WORDS = 16'(IMEM_WORDS);

  loader_state_t     state_q;
  loader_state_t     state_d;
  logic [15:0]       len_q;
  logic [15:0]       len_d;
  logic [15:0]       word_idx_q;
  logic [15:0]       word_idx_d;

  logic              byte_ready_q;
  logic              imem_we_q;
  logic [63:0]       imem_addr_q;
  logic [WORD_W-1:0] imem_wdata_q;
  logic              cpu_reset_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic              packer_clear;
  logic              packer_accept;
  logic [WORD_W-1:0] packed_word;
  logic              word_full;
  logic [15:0]       len_full;

  // byte_ready is a registered copy of "next state consumes bytes", so the
  // handshake is decided purely from registered state.
  assign accept        = strm.byte_valid && byte_ready_q;
  assign packer_accept = accept && (state_q == DATA);
  assign len_full      = {strm.byte_in, len_q[7:0]};

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (packer_clear),
    .accept_i   (packer_accept),
    .byte_i     (strm.byte_in),
    .word_o     (packed_word),
    .word_full_o(word_full)
  );

  // Loader FSM. A new load may only begin from a resting state; the word
  // index and the packer byte count are cleared whenever LEN_LO is entered.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    packer_clear = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d      = LEN_LO;
          word_idx_d   = '0;
          packer_clear = 1'b1;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d   = {8'h00, strm.byte_in};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        // The length is validated against memory capacity as its high byte
        // arrives, so an oversized or empty program never writes anything.
        if (accept) begin
          len_d = len_full;
          if ((len_full != 16'd0) && (len_full <= MAX_WORDS)) begin
            state_d = DATA;
          end else begin
            state_d = ERR;
          end
        end
      end
      DATA: begin
        if (word_full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (word_idx_q == (len_q - 16'd1)) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + 16'd1;
          state_d    = DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
    end
  end

  // Every output is registered from the next state, so each one reflects
  // the state the FSM occupies during that cycle. Address and data are
  // captured on the edge that completes a word and then held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      byte_ready_q <= is_stream_state(state_d);
      imem_we_q    <= (state_d == WRITE);
      if ((state_q == DATA) && word_full) begin
        imem_addr_q  <= {46'd0, word_idx_q, 2'b00};
        imem_wdata_q <= packed_word;
      end
      cpu_reset_q  <= (state_d != DONE);
      done_q       <= (state_d == DONE);
      error_q      <= (state_d == ERR);
    end
  end

  assign strm.byte_ready = byte_ready_q;
  assign imem_we         = imem_we_q;
  assign imem_addr       = imem_addr_q;
  assign imem_wdata      = imem_wdata_q;
  assign cpu_reset       = cpu_reset_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule
